// File: rtl/board_sequencer_if.sv
// rtl/board_sequencer_if.sv - board sequencer signal bundle: frame/player inputs and board offset outputs
interface board_sequencer_if;
  logic        vblnk_in;
  logic [11:0] p1_xpos;
  logic [11:0] p2_xpos;
  logic [1:0]  right_of_way;
  logic        game_restart;
  logic [2:0]  board_controller;
  logic        board_change;
  logic        transition_busy;
  logic        respawn;
  logic        win_p1;
  logic        win_p2;
  logic [1:0]  torch_frame;

  // Timing chain / game logic side: drives frame and player state, reads board state
  modport master (
    output vblnk_in, p1_xpos, p2_xpos, right_of_way, game_restart,
    input  board_controller, board_change, transition_busy, respawn,
           win_p1, win_p2, torch_frame
  );

  // Sequencer side
  modport slave (
    input  vblnk_in, p1_xpos, p2_xpos, right_of_way, game_restart,
    output board_controller, board_change, transition_busy, respawn,
           win_p1, win_p2, torch_frame
  );
endinterface

// File: rtl/board_sequencer.sv
// rtl/board_sequencer.sv - arena board offset sequencer (optional torch animation via TORCH_ANIM_EN)
module board_sequencer #(
  parameter int EDGE_RIGHT   = 1000,
  parameter int EDGE_LEFT    = 24,
  parameter int TRANS_FRAMES = 30,
  parameter int TORCH_DIV    = 8
) (
  input logic               clk,
  input logic               reset,
  board_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_TRANS = 2'd1,
    ST_WIN   = 2'd2
  } state_t;

  localparam int          CW         = (TRANS_FRAMES > 1) ? $clog2(TRANS_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TRANS_FRAMES - 1);
  localparam logic [11:0] EDGE_R     = 12'(EDGE_RIGHT);
  localparam logic [11:0] EDGE_L     = 12'(EDGE_LEFT);
  localparam logic [2:0]  OFF_MAX    = 3'b010;  // +2
  localparam logic [2:0]  OFF_MIN    = 3'b110;  // -2

  logic          vblnk_d_q;
  logic          arm_q;
  logic          tick_d;
  logic          tick_q;
  state_t        state_q;
  logic [2:0]    offset_q;
  logic [CW-1:0] cnt_q;
  logic          change_q;
  logic          busy_q;
  logic          respawn_q;
  logic          win1_q;
  logic          win2_q;
  logic          p1_exit;
  logic          p2_exit;

  // arm_q suppresses the first post-reset sample so a vblank already high at
  // reset release is not mistaken for a fresh rising edge.
  assign tick_d  = bus.vblnk_in & ~vblnk_d_q & arm_q;

  assign p1_exit = (bus.right_of_way == 2'b01) && (bus.p1_xpos >= EDGE_R);
  assign p2_exit = (bus.right_of_way == 2'b10) && (bus.p2_xpos <= EDGE_L);

  // Vblank rising-edge detector, registered so decisions land one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblnk_d_q <= 1'b0;
      arm_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      vblnk_d_q <= bus.vblnk_in;
      arm_q     <= 1'b1;
      tick_q    <= tick_d;
    end
  end

  // Board FSM: restart has priority over any frame tick in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_PLAY;
      offset_q  <= 3'b000;
      cnt_q     <= '0;
      change_q  <= 1'b0;
      busy_q    <= 1'b0;
      respawn_q <= 1'b0;
      win1_q    <= 1'b0;
      win2_q    <= 1'b0;
    end else begin
      change_q  <= 1'b0;
      respawn_q <= 1'b0;
      if (bus.game_restart) begin
        change_q  <= (offset_q != 3'b000);
        offset_q  <= 3'b000;
        win1_q    <= 1'b0;
        win2_q    <= 1'b0;
        busy_q    <= 1'b0;
        cnt_q     <= '0;
        respawn_q <= 1'b1;
        state_q   <= ST_PLAY;
      end else if (tick_q) begin
        case (state_q)
          ST_PLAY: begin
            if (p1_exit) begin
              if (offset_q != OFF_MAX) begin
                offset_q <= offset_q + 3'd1;
                change_q <= 1'b1;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                state_q  <= ST_TRANS;
              end else begin
                win1_q  <= 1'b1;
                state_q <= ST_WIN;
              end
            end else if (p2_exit) begin
              if (offset_q != OFF_MIN) begin
                offset_q <= offset_q - 3'd1;
                change_q <= 1'b1;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                state_q  <= ST_TRANS;
              end else begin
                win2_q  <= 1'b1;
                state_q <= ST_WIN;
              end
            end
          end
          ST_TRANS: begin
            if (cnt_q == CNT_LAST) begin
              busy_q    <= 1'b0;
              respawn_q <= 1'b1;
              state_q   <= ST_PLAY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_WIN: begin
            state_q <= ST_WIN;
          end
          default: begin
            state_q <= ST_PLAY;
          end
        endcase
      end
    end
  end

  assign bus.board_controller = offset_q;
  assign bus.board_change     = change_q;
  assign bus.transition_busy  = busy_q;
  assign bus.respawn          = respawn_q;
  assign bus.win_p1           = win1_q;
  assign bus.win_p2           = win2_q;

`ifdef TORCH_ANIM_EN
  localparam int            DW       = (TORCH_DIV > 1) ? $clog2(TORCH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TORCH_DIV - 1);

  logic [DW-1:0] div_q;
  logic [1:0]    torch_q;

  // Torch divider runs on every frame tick regardless of game state or restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      torch_q <= 2'b00;
    end else if (tick_q) begin
      if (div_q == DIV_LAST) begin
        div_q   <= '0;
        torch_q <= torch_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign bus.torch_frame = torch_q;
`else
  logic unused_torch_div;
  assign unused_torch_div = ^32'(TORCH_DIV);
  assign bus.torch_frame  = 2'b00;
`endif

endmodule

// File: doc/board_sequencer.md
Name: board_sequencer

Overview:
- Produces the 3-bit `board_controller` offset consumed by the background/board renderer. It is the writer end of that interface.
- Tracks which of the five arena boards is on screen, from the player positions and the right-of-way flag.
- Updates only at frame boundaries, on the vblank rising edge.
- Sequences a multi-frame transition when a board changes, and latches a winner when the final board edge is crossed.

Parameters:
- EDGE_RIGHT, 1000, hcount at or above which the right-moving player exits right.
- EDGE_LEFT, 24, hcount at or below which the left-moving player exits left.
- TRANS_FRAMES, 30, frames the transition_busy window lasts after a board change.
- TORCH_DIV, 8, frames per torch animation step (optional feature only).

Ports:
- clk  input  1  pixel clock.
- reset  input  1  asynchronous reset, active-low.
- vblnk_in  input  1  vertical blank from the timing chain.
- p1_xpos  input  12  player 1 x position.
- p2_xpos  input  12  player 2 x position.
- right_of_way  input  2  01 = p1 advancing right; 10 = p2 advancing left; 00/11 = none.
- game_restart  input  1  one-cycle request to restart the match.
- board_controller  output  3  two's-complement board offset, -2..+2 (110, 111, 000, 001, 010).
- board_change  output  1  one-cycle pulse when board_controller changes.
- transition_busy  output  1  high during a transition window.
- respawn  output  1  one-cycle pulse at the end of a transition.
- win_p1  output  1  sticky: p1 has won.
- win_p2  output  1  sticky: p2 has won.
- torch_frame  output  2  torch sprite animation index.

Behaviour:
- Reset (reset low, asynchronous), all outputs:
  - board_controller = 000; board_change = 0; transition_busy = 0; respawn = 0.
  - win_p1 = 0; win_p2 = 0; torch_frame = 00.
  - Internal: state = PLAY, frame counter = 0, vblnk_in delay register = 0.
- Frame tick: tick = vblnk_in & ~vblnk_d, registered one cycle. All decisions below occur only on a tick cycle, except game_restart.
- State PLAY:
  - right_of_way = 01, p1_xpos >= EDGE_RIGHT, offset < +2: offset +1 → TRANS.
  - right_of_way = 10, p2_xpos <= EDGE_LEFT, offset > -2: offset -1 → TRANS.
  - Same conditions with offset = +2 (p1) or -2 (p2): set win_p1 or win_p2 → WIN. Offset is unchanged.
  - right_of_way = 00 or 11: no action.
- On entry to TRANS:
  - board_change pulses high in the same cycle board_controller updates.
  - transition_busy = 1; frame counter = 0.
- State TRANS:
  - Counter increments each tick.
  - When the counter reaches TRANS_FRAMES-1 on a tick: transition_busy → 0, respawn pulses for one cycle, state → PLAY.
  - Edge conditions are ignored while in TRANS.
- State WIN: offset is held, win flag is held, and all tick logic is ignored until game_restart.
- game_restart, in any state:
  - Next cycle: offset = 000, win flags = 0, transition_busy = 0, state = PLAY, respawn pulses once.
  - board_change pulses only if the offset was non-zero.
  - If game_restart and a tick occur in the same cycle, game_restart wins and the tick is discarded.
- Offset arithmetic: 3-bit two's complement, saturating at ±2. No value outside {110, 111, 000, 001, 010} is ever driven.
- Latency: board_controller updates two clk cycles after the vblnk_in rising edge (edge detect register + state register), so it is stable before active video.
- vblnk_in held high across reset release: no tick is generated until the next rising edge.

Optional Feature:
- Macro TORCH_ANIM_EN.
- Defined: a frame divider counts ticks; every TORCH_DIV ticks torch_frame increments modulo 4. It continues in every state and resets to 00 on reset; game_restart does not reset it.
- Undefined: torch_frame is tied to 00 and the divider is not built.

Test Plan:
- Reset low mid-TRANS (offset +1) → board_controller = 000, transition_busy = 0 immediately, without waiting for a clk edge.
- right_of_way = 01, p1_xpos = 1000, one vblank edge → board_controller = 001 two cycles later, board_change 1-cycle pulse, transition_busy = 1.
- Same condition then held for 30 frames → respawn pulses on the 30th tick. Throughout the window board_controller stays 001; no extra increment occurs despite p1_xpos staying at 1000.
- Drive offset to +2 (two transitions), then p1 crosses again → win_p1 = 1, board_controller = 010 held. game_restart → 000, win_p1 = 0, board_change + respawn pulse.
- right_of_way = 10, p2_xpos = 24 repeatedly → offsets 111, 110, then win_p2. Also p2_xpos = 25 → no change. right_of_way = 11 with both players at edges → no change.
- TORCH_ANIM_EN defined, TORCH_DIV = 8 → torch_frame steps 0,1,2,3,0 at ticks 8, 16, 24, 32. With the macro undefined → stays 00.
